mem_io_bus: RTL and testbench

//  Memory/IO slave sitting directly downstream of the CPU: consumes mem_cmd, mem_addr and

---
 rtl/mem_io_bus.sv | 136 +++++++++++++
 tb/tb_mem_io_bus.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bus.sv
// Memory/IO slave: 256x16 RAM, LED register and switch port behind a wait-state handshake.
module mem_io_bus #(
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [8:0]  LED_ADDR    = 9'h100,
    parameter logic [8:0]  SW_ADDR     = 9'h140,
    parameter string       INIT_FILE   = "data.txt"
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    input  logic [7:0]  SW,
    output logic [15:0] read_data,
    output logic        mem_ready,
    output logic        bus_err,
    output logic [7:0]  LEDR
);

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;
    localparam logic [1:0] MILL   = 2'b11;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        go_done;
    logic [1:0]  cmd_q;
    logic [8:0]  addr_q;
    logic [15:0] data_q;
    logic        err_q;
    logic [7:0]  sw_meta, sw_sync;
    logic [15:0] ram [256];

    logic [1:0]  eff_cmd;
    logic [8:0]  eff_addr;
    logic [15:0] eff_data;
    logic        is_ram, is_led, is_sw, is_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        go_done    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_cmd != MNONE) begin
                    if (WAIT_STATES == 0) begin
                        state_next = DONE;
                        go_done    = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = DONE;
                    go_done    = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accept edge, so use the live inputs.
    always_comb begin
        eff_cmd  = (state == IDLE) ? mem_cmd    : cmd_q;
        eff_addr = (state == IDLE) ? mem_addr   : addr_q;
        eff_data = (state == IDLE) ? write_data : data_q;
        is_ram   = !eff_addr[8];
        is_led   = (eff_addr == LED_ADDR);
        is_sw    = (eff_addr == SW_ADDR);
        is_err   = (eff_cmd == MILL) || !(is_ram || is_led || is_sw);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q     <= MNONE;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            read_data <= '0;
            LEDR      <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
            if (state == IDLE && mem_cmd != MNONE) begin
                cmd_q  <= mem_cmd;
                addr_q <= mem_addr;
                data_q <= write_data;
            end
            if (go_done) begin
                err_q <= is_err;
                case (eff_cmd)
                    MREAD: begin
                        if (is_ram)      read_data <= ram[eff_addr[7:0]];
                        else if (is_led) read_data <= {8'h00, LEDR};
                        else if (is_sw)  read_data <= {8'h00, sw_sync};
                        else             read_data <= '0;
                    end
                    MWRITE:  if (is_led) LEDR <= eff_data[7:0];
                    MILL:    read_data <= '0;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (go_done && eff_cmd == MWRITE && is_ram)
            ram[eff_addr[7:0]] <= eff_data;
    end

    assign mem_ready = (state == DONE);
    assign bus_err   = (state == DONE) && err_q;

endmodule

// File: tb/tb_mem_io_bus.sv
// Bench for mem_io_bus: two instances (0 and 1 wait states) checked against an address-map model.
module tb_mem_io_bus;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [8:0]  addr = '0;
    logic [15:0] wd = '0;
    logic [7:0]  sw = '0;
    logic [1:0]  cmd_a [2];
    logic [15:0] rd_a  [2];
    logic        rdy_a [2];
    logic        err_a [2];
    logic [7:0]  led_a [2];

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_ram [2][256];
    bit          m_val [2][256];
    logic [7:0]  m_led [2];
    logic [15:0] m_rd  [2];
    logic [7:0]  m_sw;

    always #5 clk = ~clk;

    mem_io_bus #(.WAIT_STATES(0)) u0 (
        .clk(clk), .reset_n(reset_n), .mem_cmd(cmd_a[0]), .mem_addr(addr),
        .write_data(wd), .SW(sw), .read_data(rd_a[0]), .mem_ready(rdy_a[0]),
        .bus_err(err_a[0]), .LEDR(led_a[0])
    );

    mem_io_bus #(.WAIT_STATES(1)) u1 (
        .clk(clk), .reset_n(reset_n), .mem_cmd(cmd_a[1]), .mem_addr(addr),
        .write_data(wd), .SW(sw), .read_data(rd_a[1]), .mem_ready(rdy_a[1]),
        .bus_err(err_a[1]), .LEDR(led_a[1])
    );

    // Reference: what each address/command means for the visible state.
    function automatic void model(input int d, input logic [1:0] c, input logic [8:0] a,
                                  input logic [15:0] w, output logic [15:0] erd, output logic eerr);
        bit in_ram, in_led, in_sw;
        in_ram = (a < 9'd256);
        in_led = (a == 9'h100);
        in_sw  = (a == 9'h140);
        eerr   = (c == 2'b11) || !(in_ram || in_led || in_sw);
        if (c == 2'b01 || c == 2'b11) begin
            if (eerr)        m_rd[d] = 16'h0000;
            else if (in_ram) m_rd[d] = m_ram[d][a[7:0]];
            else if (in_led) m_rd[d] = {8'h00, m_led[d]};
            else             m_rd[d] = {8'h00, m_sw};
        end else if (c == 2'b10 && !eerr) begin
            if (in_ram) begin
                m_ram[d][a[7:0]] = w;
                m_val[d][a[7:0]] = 1'b1;
            end else if (in_led) begin
                m_led[d] = w[7:0];
            end
        end
        erd = m_rd[d];
    endfunction

    task automatic xact(input int d, input logic [1:0] c, input logic [8:0] a, input logic [15:0] w,
                        output int lat, output logic [15:0] rd, output logic er);
        @(negedge clk);
        addr = a;
        wd = w;
        cmd_a[d] = c;
        lat = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            lat++;
            if (rdy_a[d] === 1'b1) break;
        end
        rd = rd_a[d];
        er = err_a[d];
        cmd_a[d] = 2'b00;
        @(posedge clk);
    endtask

    task automatic set_sw(input logic [7:0] v);
        @(negedge clk);
        sw = v;
        m_sw = v;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (rd_a[d] !== 16'h0000) begin n_bad++; $display("FAIL reset_rd[%0d] got %h want 0000", d, rd_a[d]); end
            n_cmp++; if (led_a[d] !== 8'h00) begin n_bad++; $display("FAIL reset_led[%0d] got %h want 00", d, led_a[d]); end
            n_cmp++; if (rdy_a[d] !== 1'b0 || err_a[d] !== 1'b0) begin n_bad++; $display("FAIL reset_hs[%0d] got rdy=%b err=%b want 0 0", d, rdy_a[d], err_a[d]); end
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        logic [15:0] rd, erd;
        logic er, eer;
        for (int d = 0; d < 2; d++) begin
            model(d, 2'b10, 9'h005, 16'h00A5, erd, eer);
            xact(d, 2'b10, 9'h005, 16'h00A5, lat, rd, er);
            n_cmp++; if (lat !== d + 1) begin n_bad++; $display("FAIL wr_latency[%0d] got %0d want %0d", d, lat, d + 1); end
            n_cmp++; if (rd !== erd || er !== 1'b0) begin n_bad++; $display("FAIL wr_rd[%0d] got %h/%b want %h/0", d, rd, er, erd); end
            model(d, 2'b01, 9'h005, 16'h0, erd, eer);
            xact(d, 2'b01, 9'h005, 16'hFFFF, lat, rd, er);
            n_cmp++; if (lat !== d + 1) begin n_bad++; $display("FAIL rd_latency[%0d] got %0d want %0d", d, lat, d + 1); end
            n_cmp++; if (rd !== 16'h00A5 || er !== 1'b0) begin n_bad++; $display("FAIL rd_ram[%0d] got %h/%b want 00a5/0", d, rd, er); end
        end
    endtask

    task automatic test_led;
        int lat;
        logic [15:0] rd, erd;
        logic er, eer;
        for (int d = 0; d < 2; d++) begin
            model(d, 2'b10, 9'h100, 16'h1234, erd, eer);
            xact(d, 2'b10, 9'h100, 16'h1234, lat, rd, er);
            n_cmp++; if (led_a[d] !== 8'h34) begin n_bad++; $display("FAIL led_wr[%0d] got %h want 34", d, led_a[d]); end
            n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL led_wr_rd_held[%0d] got %h want %h", d, rd, erd); end
            model(d, 2'b01, 9'h100, 16'h0, erd, eer);
            xact(d, 2'b01, 9'h100, 16'h0, lat, rd, er);
            n_cmp++; if (rd !== 16'h0034 || er !== 1'b0) begin n_bad++; $display("FAIL led_rd[%0d] got %h/%b want 0034/0", d, rd, er); end
        end
    endtask

    task automatic test_switch;
        int lat;
        logic [15:0] rd, erd;
        logic er, eer;
        set_sw(8'h5A);
        for (int d = 0; d < 2; d++) begin
            model(d, 2'b01, 9'h140, 16'h0, erd, eer);
            xact(d, 2'b01, 9'h140, 16'h0, lat, rd, er);
            n_cmp++; if (rd !== 16'h005A || er !== 1'b0) begin n_bad++; $display("FAIL sw_rd[%0d] got %h/%b want 005a/0", d, rd, er); end
            model(d, 2'b10, 9'h140, 16'hFFFF, erd, eer);
            xact(d, 2'b10, 9'h140, 16'hFFFF, lat, rd, er);
            n_cmp++; if (rd !== 16'h005A || er !== 1'b0 || led_a[d] !== m_led[d]) begin n_bad++; $display("FAIL sw_wr_ignored[%0d] got %h/%b/%h want 005a/0/%h", d, rd, er, led_a[d], m_led[d]); end
        end
    endtask

    task automatic test_unmapped;
        int lat;
        logic [15:0] rd, erd;
        logic er, eer;
        for (int d = 0; d < 2; d++) begin
            model(d, 2'b01, 9'h005, 16'h0, erd, eer);
            xact(d, 2'b01, 9'h005, 16'h0, lat, rd, er);
            model(d, 2'b01, 9'h1FF, 16'h0, erd, eer);
            xact(d, 2'b01, 9'h1FF, 16'h0, lat, rd, er);
            n_cmp++; if (rd !== 16'h0000 || er !== 1'b1 || lat !== d + 1) begin n_bad++; $display("FAIL unmapped_rd[%0d] got %h/%b lat %0d want 0000/1 lat %0d", d, rd, er, lat, d + 1); end
            model(d, 2'b01, 9'h005, 16'h0, erd, eer);
            xact(d, 2'b01, 9'h005, 16'h0, lat, rd, er);
            model(d, 2'b11, 9'h005, 16'h7777, erd, eer);
            xact(d, 2'b11, 9'h005, 16'h7777, lat, rd, er);
            n_cmp++; if (rd !== 16'h0000 || er !== 1'b1) begin n_bad++; $display("FAIL illegal_cmd[%0d] got %h/%b want 0000/1", d, rd, er); end
            model(d, 2'b01, 9'h005, 16'h0, erd, eer);
            xact(d, 2'b01, 9'h005, 16'h0, lat, rd, er);
            n_cmp++; if (rd !== 16'h00A5 || er !== 1'b0) begin n_bad++; $display("FAIL illegal_no_write[%0d] got %h/%b want 00a5/0", d, rd, er); end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] erd;
        logic eer;
        bit exp_rdy;
        for (int d = 0; d < 2; d++) begin
            model(d, 2'b01, 9'h005, 16'h0, erd, eer);
            @(negedge clk);
            addr = 9'h005;
            cmd_a[d] = 2'b01;
            for (int k = 1; k <= 3 * (d + 2); k++) begin
                @(posedge clk);
                #1;
                exp_rdy = ((k % (d + 2)) == d + 1);
                n_cmp++; if (rdy_a[d] !== exp_rdy) begin n_bad++; $display("FAIL b2b_ready[%0d] cycle %0d got %b want %b", d, k, rdy_a[d], exp_rdy); end
                if (exp_rdy) begin
                    n_cmp++; if (rd_a[d] !== erd) begin n_bad++; $display("FAIL b2b_data[%0d] got %h want %h", d, rd_a[d], erd); end
                end
            end
            cmd_a[d] = 2'b00;
            @(posedge clk);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [15:0] rd, erd;
        logic er, eer;
        model(1, 2'b10, 9'h010, 16'h1111, erd, eer);
        xact(1, 2'b10, 9'h010, 16'h1111, lat, rd, er);
        @(negedge clk);
        addr = 9'h010;
        wd = 16'hBEEF;
        cmd_a[1] = 2'b10;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        cmd_a[1] = 2'b00;
        n_cmp++; if (rdy_a[1] !== 1'b0 || err_a[1] !== 1'b0) begin n_bad++; $display("FAIL midreset_hs got rdy=%b err=%b want 0 0", rdy_a[1], err_a[1]); end
        n_cmp++; if (rd_a[1] !== 16'h0000 || led_a[1] !== 8'h00) begin n_bad++; $display("FAIL midreset_regs got %h/%h want 0000/00", rd_a[1], led_a[1]); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (rdy_a[1] !== 1'b0) begin n_bad++; $display("FAIL midreset_no_ready got %b want 0", rdy_a[1]); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_led[d] = 8'h00;
            m_rd[d] = 16'h0000;
        end
        model(1, 2'b01, 9'h010, 16'h0, erd, eer);
        xact(1, 2'b01, 9'h010, 16'h0, lat, rd, er);
        n_cmp++; if (rd !== 16'h1111 || er !== 1'b0) begin n_bad++; $display("FAIL midreset_ram got %h/%b want 1111/0", rd, er); end
    endtask

    task automatic test_random;
        int lat, r;
        logic [1:0] c;
        logic [8:0] a;
        logic [15:0] w, rd, erd;
        logic er, eer;
        for (int n = 0; n < 120; n++) begin
            int d;
            d = n % 2;
            if ($urandom_range(0, 5) == 0) set_sw(8'($urandom));
            r = $urandom_range(0, 9);
            if (r <= 5)      a = 9'($urandom_range(0, 15));
            else if (r == 6) a = 9'h100;
            else if (r == 7) a = 9'h140;
            else begin
                a = {1'b1, 8'($urandom)};
                if (a == 9'h100 || a == 9'h140) a = 9'h1FF;
            end
            r = $urandom_range(0, 9);
            c = (r <= 4) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
            if (c == 2'b01 && a < 9'd256 && !m_val[d][a[7:0]]) c = 2'b10;
            w = 16'($urandom);
            model(d, c, a, w, erd, eer);
            xact(d, c, a, w, lat, rd, er);
            n_cmp++; if (lat !== d + 1) begin n_bad++; $display("FAIL rnd_latency[%0d] op %0d got %0d want %0d", d, n, lat, d + 1); end
            n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL rnd_rd[%0d] op %0d cmd %b addr %h got %h want %h", d, n, c, a, rd, erd); end
            n_cmp++; if (er !== eer) begin n_bad++; $display("FAIL rnd_err[%0d] op %0d cmd %b addr %h got %b want %b", d, n, c, a, er, eer); end
            n_cmp++; if (led_a[d] !== m_led[d]) begin n_bad++; $display("FAIL rnd_led[%0d] op %0d got %h want %h", d, n, led_a[d], m_led[d]); end
        end
    endtask

    initial begin
        cmd_a[0] = 2'b00;
        cmd_a[1] = 2'b00;
        m_sw = 8'h00;
        for (int d = 0; d < 2; d++) begin
            m_led[d] = 8'h00;
            m_rd[d] = 16'h0000;
            for (int i = 0; i < 256; i++) m_val[d][i] = 1'b0;
        end
        test_reset;
        test_basic;
        test_led;
        test_switch;
        test_unmapped;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
